// File: rtl/regfile8.sv
// Eight-entry register file with two combinational read ports, same-cycle
// write bypass, a hardwired zero register and a per-register pending scoreboard.
module regfile8 #(
  parameter int WIDTH    = 64,
  parameter int ZERO_REG = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [2:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             issue_en,
  input  logic [2:0]       issue_addr,
  input  logic [2:0]       rd_addr_a,
  input  logic [2:0]       rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             busy_a,
  output logic             busy_b,
  output logic [7:0]       busy
);

  localparam logic [2:0] ZERO_IDX = 3'(ZERO_REG);

  logic [WIDTH-1:0] regs [8];
  logic [7:0]       busy_next;
  logic             wr_valid;

  assign wr_valid = wr_en && (wr_addr != ZERO_IDX);

  // Issue is applied after writeback so a same-cycle issue wins over the clear.
  always_comb begin
    busy_next = busy;
    if (wr_en) begin
      busy_next[wr_addr] = 1'b0;
    end
    if (issue_en && (issue_addr != ZERO_IDX)) begin
      busy_next[issue_addr] = 1'b1;
    end
    busy_next[ZERO_IDX] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) begin
        regs[i] <= '0;
      end
      busy <= '0;
    end else begin
      if (wr_valid) begin
        regs[wr_addr] <= wr_data;
      end
      busy <= busy_next;
    end
  end

  // A writeback in flight makes the operand both visible and valid this cycle.
  always_comb begin
    rd_data_a = (rd_addr_a == ZERO_IDX) ? '0 : regs[rd_addr_a];
    rd_data_b = (rd_addr_b == ZERO_IDX) ? '0 : regs[rd_addr_b];
    if (wr_valid && (wr_addr == rd_addr_a)) begin
      rd_data_a = wr_data;
    end
    if (wr_valid && (wr_addr == rd_addr_b)) begin
      rd_data_b = wr_data;
    end
    busy_a = busy[rd_addr_a] && !(wr_en && (wr_addr == rd_addr_a));
    busy_b = busy[rd_addr_b] && !(wr_en && (wr_addr == rd_addr_b));
  end

endmodule

// File: tb/tb_regfile8.sv
// Directed, table-driven bench for regfile8: reset behaviour, readback, bypass,
// scoreboard set/clear priority and a swept comparison against a reference model.
module tb_regfile8;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [63:0] wr_data;
  logic        issue_en;
  logic [2:0]  issue_addr;
  logic [2:0]  rd_addr_a;
  logic [2:0]  rd_addr_b;
  logic [63:0] rd_data_a;
  logic [63:0] rd_data_b;
  logic        busy_a;
  logic        busy_b;
  logic [7:0]  busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [2:0]  wa;
    logic [63:0] wd;
    logic        ie;
    logic [2:0]  ia;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [63:0] exp_a;
    logic [63:0] exp_b;
    logic        exp_ba;
    logic        exp_bb;
    logic [7:0]  exp_busy;
  } vec_t;

  vec_t vecs [12];

  logic [63:0] mregs [8];
  logic [7:0]  mbusy;

  regfile8 dut (
    .clk(clk),
    .reset(reset),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .issue_en(issue_en),
    .issue_addr(issue_addr),
    .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a),
    .rd_data_b(rd_data_b),
    .busy_a(busy_a),
    .busy_b(busy_b),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic we, input logic [2:0] wa, input logic [63:0] wd,
                               input logic ie, input logic [2:0] ia,
                               input logic [2:0] ra, input logic [2:0] rb);
    wr_en      = we;
    wr_addr    = wa;
    wr_data    = wd;
    issue_en   = ie;
    issue_addr = ia;
    rd_addr_a  = ra;
    rd_addr_b  = rb;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic writeReg(input logic [2:0] addr, input logic [63:0] data);
    applyStimulus(1'b1, addr, data, 1'b0, 3'd0, 3'd0, 3'd0);
    tick();
  endtask

  initial begin
    // Table rows: inputs held for one cycle, outputs sampled before the edge.
    // Register state entering the table: Ri = i*0x11 except R2 = 0x9, busy = 0.
    vecs[0]  = '{1'b0, 3'd0, 64'h0,    1'b1, 3'd4, 3'd4, 3'd0, 64'h44,   64'h0,    1'b0, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 3'd4, 64'hA4,   1'b0, 3'd0, 3'd4, 3'd4, 64'hA4,   64'hA4,   1'b0, 1'b0, 8'h10};
    vecs[2]  = '{1'b0, 3'd0, 64'h0,    1'b0, 3'd0, 3'd4, 3'd1, 64'hA4,   64'h11,   1'b0, 1'b0, 8'h00};
    vecs[3]  = '{1'b0, 3'd0, 64'h0,    1'b1, 3'd1, 3'd1, 3'd4, 64'h11,   64'hA4,   1'b0, 1'b0, 8'h00};
    vecs[4]  = '{1'b1, 3'd1, 64'h3,    1'b1, 3'd1, 3'd1, 3'd5, 64'h3,    64'h55,   1'b0, 1'b0, 8'h02};
    vecs[5]  = '{1'b0, 3'd0, 64'h0,    1'b0, 3'd0, 3'd1, 3'd7, 64'h3,    64'h0,    1'b1, 1'b0, 8'h02};
    vecs[6]  = '{1'b0, 3'd0, 64'h0,    1'b1, 3'd7, 3'd7, 3'd1, 64'h0,    64'h3,    1'b0, 1'b1, 8'h02};
    vecs[7]  = '{1'b1, 3'd7, 64'hFF,   1'b0, 3'd0, 3'd7, 3'd1, 64'h0,    64'h3,    1'b0, 1'b1, 8'h02};
    vecs[8]  = '{1'b1, 3'd1, 64'h77,   1'b1, 3'd6, 3'd6, 3'd1, 64'h66,   64'h77,   1'b0, 1'b0, 8'h02};
    vecs[9]  = '{1'b1, 3'd6, 64'h12,   1'b1, 3'd3, 3'd6, 3'd3, 64'h12,   64'h33,   1'b0, 1'b0, 8'h40};
    vecs[10] = '{1'b1, 3'd5, 64'hBEEF, 1'b0, 3'd0, 3'd3, 3'd5, 64'h33,   64'hBEEF, 1'b1, 1'b0, 8'h08};
    vecs[11] = '{1'b0, 3'd0, 64'h0,    1'b0, 3'd0, 3'd5, 3'd3, 64'hBEEF, 64'h33,   1'b0, 1'b1, 8'h08};

    // Power-up with reset held low.
    reset = 1'b0;
    applyStimulus(1'b0, 3'd0, 64'h0, 1'b0, 3'd0, 3'd3, 3'd5);
    #2;
    checkOutput("reset rd_a", rd_data_a, 64'h0);
    checkOutput("reset rd_b", rd_data_b, 64'h0);
    checkOutput("reset busy", {56'h0, busy}, 64'h0);
    checkOutput("reset busy_a", {63'h0, busy_a}, 64'h0);

    // Bypass works during reset, but the edge must not commit the write or issue.
    applyStimulus(1'b1, 3'd2, 64'h55, 1'b1, 3'd2, 3'd2, 3'd2);
    #1;
    checkOutput("reset bypass rd_a", rd_data_a, 64'h55);
    checkOutput("reset bypass busy_a", {63'h0, busy_a}, 64'h0);
    tick();
    applyStimulus(1'b0, 3'd0, 64'h0, 1'b0, 3'd0, 3'd2, 3'd2);
    #1;
    checkOutput("reset discard rd_a", rd_data_a, 64'h0);
    checkOutput("reset discard busy", {56'h0, busy}, 64'h0);

    // Release between edges; the very next edge must accept traffic.
    #2 reset = 1'b1;
    applyStimulus(1'b1, 3'd0, 64'h99, 1'b1, 3'd5, 3'd0, 3'd5);
    tick();
    applyStimulus(1'b0, 3'd0, 64'h0, 1'b0, 3'd0, 3'd0, 3'd5);
    #1;
    checkOutput("first write R0", rd_data_a, 64'h99);
    checkOutput("first issue busy", {56'h0, busy}, 64'h20);
    checkOutput("first issue busy_b", {63'h0, busy_b}, 64'h1);

    // Write/readback of all registers; R7 stays zero.
    for (int i = 0; i < 7; i++) begin
      writeReg(3'(i), 64'(i * 'h11));
    end
    writeReg(3'd7, 64'hFF);
    for (int a = 0; a < 8; a++) begin
      applyStimulus(1'b0, 3'd0, 64'h0, 1'b0, 3'd0, 3'(a), 3'(7 - a));
      #1;
      checkOutput($sformatf("readback a R%0d", a), rd_data_a, (a == 7) ? 64'h0 : 64'(a * 'h11));
      checkOutput($sformatf("readback b R%0d", 7 - a), rd_data_b, (a == 0) ? 64'h0 : 64'((7 - a) * 'h11));
    end
    checkOutput("busy after writebacks", {56'h0, busy}, 64'h0);

    // Same-cycle bypass on both ports, then the committed value after the edge.
    writeReg(3'd2, 64'h5);
    applyStimulus(1'b1, 3'd2, 64'h9, 1'b0, 3'd0, 3'd2, 3'd2);
    #1;
    checkOutput("bypass pre-edge a", rd_data_a, 64'h9);
    checkOutput("bypass pre-edge b", rd_data_b, 64'h9);
    tick();
    applyStimulus(1'b0, 3'd0, 64'h0, 1'b0, 3'd0, 3'd2, 3'd2);
    #1;
    checkOutput("bypass post-edge a", rd_data_a, 64'h9);
    checkOutput("bypass post-edge b", rd_data_b, 64'h9);
    tick();

    // Scoreboard and collision table.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ie, vecs[i].ia, vecs[i].ra, vecs[i].rb);
      #1;
      checkOutput($sformatf("vec%0d rd_a", i), rd_data_a, vecs[i].exp_a);
      checkOutput($sformatf("vec%0d rd_b", i), rd_data_b, vecs[i].exp_b);
      checkOutput($sformatf("vec%0d busy_a", i), {63'h0, busy_a}, {63'h0, vecs[i].exp_ba});
      checkOutput($sformatf("vec%0d busy_b", i), {63'h0, busy_b}, {63'h0, vecs[i].exp_bb});
      checkOutput($sformatf("vec%0d busy", i), {56'h0, busy}, {56'h0, vecs[i].exp_busy});
      tick();
    end

    // Reset asserted mid-cycle clears state without waiting for a clock.
    applyStimulus(1'b1, 3'd3, 64'hAB, 1'b1, 3'd3, 3'd3, 3'd3);
    tick();
    applyStimulus(1'b0, 3'd0, 64'h0, 1'b0, 3'd0, 3'd3, 3'd3);
    #1;
    checkOutput("pre-reset R3", rd_data_a, 64'hAB);
    checkOutput("pre-reset busy", {56'h0, busy}, 64'h08);
    #2 reset = 1'b0;
    #1;
    checkOutput("async reset R3", rd_data_a, 64'h0);
    checkOutput("async reset busy", {56'h0, busy}, 64'h0);
    checkOutput("async reset busy_a", {63'h0, busy_a}, 64'h0);
    tick();
    #2 reset = 1'b1;
    tick();

    // Sweep wr_en x wr_addr x rd_addr_a against a reference model.
    for (int i = 0; i < 8; i++) begin
      mregs[i] = 64'h0;
    end
    mbusy = 8'h00;
    for (int i = 0; i < 7; i++) begin
      writeReg(3'(i), 64'hA000 + 64'(i));
      mregs[i] = 64'hA000 + 64'(i);
    end
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 3'd0, 64'h0, 1'b1, 3'(i), 3'd0, 3'd0);
      tick();
      mbusy[i] = 1'b1;
    end
    applyStimulus(1'b0, 3'd0, 64'h0, 1'b0, 3'd0, 3'd0, 3'd0);
    #1;
    checkOutput("sweep preload busy", {56'h0, busy}, 64'h7F);

    for (int we = 0; we < 2; we++) begin
      for (int wa = 0; wa < 8; wa++) begin
        for (int ra = 0; ra < 8; ra++) begin
          logic [63:0] wd;
          logic [63:0] exp_a;
          logic [63:0] exp_b;
          logic        exp_ba;
          logic [2:0]  rb;
          logic [2:0]  ia;
          logic        hit_a;
          logic        hit_b;
          wd = 64'hC000_0000 + 64'(we * 64 + wa * 8 + ra);
          rb = 3'(ra) ^ 3'd5;
          ia = 3'(ra + wa);
          applyStimulus(we[0], 3'(wa), wd, 1'b1, ia, 3'(ra), rb);
          #1;
          hit_a  = (we == 1) && (wa == ra);
          hit_b  = (we == 1) && (3'(wa) == rb);
          exp_a  = (hit_a && wa != 7) ? wd : ((ra == 7) ? 64'h0 : mregs[ra]);
          exp_b  = (hit_b && wa != 7) ? wd : ((rb == 3'd7) ? 64'h0 : mregs[rb]);
          exp_ba = mbusy[ra] && !hit_a;
          checkOutput($sformatf("sweep we%0d wa%0d ra%0d rd_a", we, wa, ra), rd_data_a, exp_a);
          checkOutput($sformatf("sweep we%0d wa%0d ra%0d rd_b", we, wa, ra), rd_data_b, exp_b);
          checkOutput($sformatf("sweep we%0d wa%0d ra%0d busy_a", we, wa, ra), {63'h0, busy_a}, {63'h0, exp_ba});
          checkOutput($sformatf("sweep we%0d wa%0d ra%0d busy", we, wa, ra), {56'h0, busy}, {56'h0, mbusy});
          tick();
          if (we == 1 && wa != 7) mregs[wa] = wd;
          if (we == 1) mbusy[wa] = 1'b0;
          if (ia != 3'd7) mbusy[ia] = 1'b1;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
